// File: rtl/serial_add_sched.sv
// rtl/serial_add_sched.sv - round-robin scheduler sharing one bit-serial adder among NREQ requesters
//
// Arbitrates NREQ requesters onto a single bit-serial adder and hands the
// result back to the granted requester with a one-cycle, one-hot ack.
// A watchdog aborts an operation whose done never arrives.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   req               per-requester request level, held until its ack
//   req_a, req_b      operands, slice i belongs to requester i
//   ack               one-hot one-cycle result strobe
//   res_sum/res_cout  result, valid with ack, held until next capture
//   res_err           timeout flag, valid with ack (sum/cout forced to 0)
//   busy              high whenever the scheduler is not idle
//   sa_in1/sa_in2     operands to the adder, registered at grant
//   sa_ld/sa_st       adder load/start strobes (one cycle, together)
//   sa_sum/sa_cout    adder result
//   sa_done           adder completion level
module serial_add_sched #(
  parameter int WIDTH   = 32,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      res_sum,
  output logic                  res_cout,
  output logic                  res_err,
  output logic                  busy,
  output logic [WIDTH-1:0]      sa_in1,
  output logic [WIDTH-1:0]      sa_in2,
  output logic                  sa_ld,
  output logic                  sa_st,
  input  logic [WIDTH-1:0]      sa_sum,
  input  logic                  sa_cout,
  input  logic                  sa_done
);

  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int IW1 = IW + 1;
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, ARM, WAIT, RESP} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   rr;
  logic [IW-1:0]   grant;
  logic [IW-1:0]   pick;
  logic            pick_vld;
  logic [IW1-1:0]  idx;
  logic [WDW-1:0]  wd;
  logic [IW-1:0]   rr_after_grant;

  // Round-robin pick: first set req bit at or after rr, wrapping.
  // Walking k downwards lets the smallest offset win the last assignment.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr} + IW1'(k);
      if (idx >= IW1'(NREQ)) idx = idx - IW1'(NREQ);
      if (req[idx[IW-1:0]]) begin
        pick     = idx[IW-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  assign rr_after_grant = (grant == IW'(NREQ - 1)) ? '0 : grant + IW'(1);

  always_comb begin
    state_nxt = state;
    sa_ld     = 1'b0;
    sa_st     = 1'b0;
    ack       = '0;
    busy      = (state != IDLE);
    case (state)
      IDLE: if (pick_vld) state_nxt = LOAD;
      LOAD: begin
        sa_ld     = 1'b1;
        sa_st     = 1'b1;
        state_nxt = ARM;
      end
      // Done may still be high from the previous operation here; ignore it.
      ARM:  state_nxt = WAIT;
      WAIT: if (sa_done || (wd == WDW'(TIMEOUT - 1))) state_nxt = RESP;
      RESP: begin
        ack[grant] = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr       <= '0;
      grant    <= '0;
      wd       <= '0;
      sa_in1   <= '0;
      sa_in2   <= '0;
      res_sum  <= '0;
      res_cout <= 1'b0;
      res_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (pick_vld) begin
          grant  <= pick;
          sa_in1 <= req_a[int'(pick)*WIDTH +: WIDTH];
          sa_in2 <= req_b[int'(pick)*WIDTH +: WIDTH];
        end
        ARM:  wd <= '0;
        WAIT: begin
          if (sa_done) begin
            res_sum  <= sa_sum;
            res_cout <= sa_cout;
            res_err  <= 1'b0;
          end else if (wd == WDW'(TIMEOUT - 1)) begin
            res_sum  <= '0;
            res_cout <= 1'b0;
            res_err  <= 1'b1;
          end else begin
            wd <= wd + WDW'(1);
          end
        end
        RESP: rr <= rr_after_grant;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sched.sv
// tb/tb_serial_add_sched.sv - self-checking bench for serial_add_sched
module tb_serial_add_sched;

  localparam int WIDTH   = 32;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      res_sum;
  logic                  res_cout;
  logic                  res_err;
  logic                  busy;
  logic [WIDTH-1:0]      sa_in1;
  logic [WIDTH-1:0]      sa_in2;
  logic                  sa_ld;
  logic                  sa_st;
  logic [WIDTH-1:0]      sa_sum  = '0;
  logic                  sa_cout = 1'b0;
  logic                  sa_done = 1'b0;

  always #5 clk = ~clk;

  serial_add_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
    .ack(ack), .res_sum(res_sum), .res_cout(res_cout), .res_err(res_err),
    .busy(busy), .sa_in1(sa_in1), .sa_in2(sa_in2), .sa_ld(sa_ld),
    .sa_st(sa_st), .sa_sum(sa_sum), .sa_cout(sa_cout), .sa_done(sa_done)
  );

  // Adder model: result appears lat cycles after the load edge.
  int             lat = 1;
  bit             stale_mode = 1'b0;
  bit             never_done = 1'b0;
  int             cnt = 0;
  logic [WIDTH:0] pend = '0;

  always @(posedge clk) begin
    if (sa_ld && sa_st) begin
      pend <= {1'b0, sa_in1} + {1'b0, sa_in2};
      cnt  <= lat;
      if (!stale_mode) sa_done <= 1'b0;
    end else if (cnt > 1) begin
      cnt     <= cnt - 1;
      sa_done <= 1'b0;
    end else if (cnt == 1) begin
      cnt <= 0;
      if (!never_done) begin
        sa_done           <= 1'b1;
        {sa_cout, sa_sum} <= pend;
      end
    end
  end

  // Reference model state
  int               checks = 0, passed = 0, fails = 0, cyc = 0;
  bit               inflight = 0, ld_prev = 0, auto_mode = 0, rand_gap = 0, rand_lat = 0;
  int               cur_g = 0, ld_cyc = 0, cur_lat = 0;
  bit               cur_never = 0;
  logic [WIDTH-1:0] cur_a = '0, cur_b = '0;
  int               model_rr = 0, acks = 0;
  int               order[$];
  logic [WIDTH-1:0] last_sum = '0;
  logic             last_cout = 1'b0, last_err = 1'b0;
  int               raise_cnt[NREQ];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick_rr(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req[i] = 1'b1;
  endtask

  task automatic tick();
    int             g;
    logic [WIDTH:0] s;
    logic [WIDTH-1:0] e_sum;
    logic           e_cout, e_err;
    int             e_lat;
    @(negedge clk);
    cyc++;
    if (sa_ld === 1'b1) begin
      g = pick_rr(req, model_rr);
      check("grant_valid", g >= 0, 1);
      if (g < 0) g = 0;
      if (rand_lat) lat = $urandom_range(1, WIDTH + 1);
      cur_g = g; cur_lat = lat; cur_never = never_done; ld_cyc = cyc; inflight = 1;
      cur_a = req_a[g*WIDTH +: WIDTH];
      cur_b = req_b[g*WIDTH +: WIDTH];
      check("sa_st", sa_st, 1);
      check("sa_in1", sa_in1, cur_a);
      check("sa_in2", sa_in2, cur_b);
      ld_prev = 1;
    end else if (ld_prev) begin
      check("ld_one_cycle", {sa_ld, sa_st}, 0);
      ld_prev = 0;
    end
    check("busy", busy, inflight);
    for (int i = 0; i < NREQ; i++) begin
      if (raise_cnt[i] > 0) begin
        raise_cnt[i]--;
        if (raise_cnt[i] == 0) set_req(i, $urandom, $urandom);
      end
    end
    if (ack != '0) begin
      check("ack_expected", inflight, 1);
      check("ack_onehot", ack, 64'(1) << cur_g);
      if (cur_never) begin
        e_sum = '0; e_cout = 1'b0; e_err = 1'b1; e_lat = TIMEOUT + 2;
      end else begin
        s = {1'b0, cur_a} + {1'b0, cur_b};
        e_sum = s[WIDTH-1:0]; e_cout = s[WIDTH]; e_err = 1'b0; e_lat = cur_lat + 2;
      end
      check("res_sum", res_sum, e_sum);
      check("res_cout", res_cout, e_cout);
      check("res_err", res_err, e_err);
      check("latency", cyc - ld_cyc, e_lat);
      last_sum = e_sum; last_cout = e_cout; last_err = e_err;
      model_rr = (cur_g + 1) % NREQ;
      inflight = 0;
      order.push_back(cur_g);
      acks++;
      req[cur_g] = 1'b0;
      if (auto_mode) raise_cnt[cur_g] = rand_gap ? $urandom_range(2, 8) : 2;
    end else begin
      check("res_hold", {res_err, res_cout, res_sum}, {last_err, last_cout, last_sum});
    end
  endtask

  task automatic wait_acks(input int n, input int budget);
    int target;
    int b;
    target = acks + n;
    b = 0;
    while (acks < target && b < budget) begin
      tick();
      b++;
    end
    check("wait_budget", acks >= target, 1);
  endtask

  task automatic reset_and_check();
    rst = 1'b1;
    #1;
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_strobes", {sa_ld, sa_st}, 0);
    check("rst_in1", sa_in1, 0);
    check("rst_in2", sa_in2, 0);
    check("rst_res", {res_err, res_cout, res_sum}, 0);
    inflight = 0; ld_prev = 0; model_rr = 0;
    last_sum = '0; last_cout = 1'b0; last_err = 1'b0;
  endtask

  initial begin
    int b;
    int acks_before;
    req = '0; req_a = '0; req_b = '0;
    for (int i = 0; i < NREQ; i++) raise_cnt[i] = 0;
    #1;
    reset_and_check();
    repeat (2) tick();
    rst = 1'b0;

    // Single operation
    lat = WIDTH;
    set_req(0, 32'd1, 32'd2);
    wait_acks(1, 200);
    check("single_id", order[$], 0);
    check("single_sum", {res_err, res_cout, res_sum}, 34'd3);

    // Carry cases
    set_req(2, 32'hFFFF_FFFF, 32'd1);
    wait_acks(1, 200);
    check("carry1_id", order[$], 2);
    check("carry1_res", {res_cout, res_sum}, {1'b1, 32'h0});
    set_req(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_acks(1, 200);
    check("carry2_res", {res_cout, res_sum}, {1'b1, 32'hFFFF_FFFE});

    // Stale done left high through the cycle after load
    stale_mode = 1'b1;
    lat = 3;
    set_req(1, 32'h1234, 32'h1111);
    wait_acks(1, 200);
    check("stale_sum", res_sum, 32'h2345);
    lat = 1;
    set_req(1, 32'h10, 32'h20);
    wait_acks(1, 200);
    check("stale_sum_fast", res_sum, 32'h30);
    stale_mode = 1'b0;

    // Watchdog timeout, then a normal op
    never_done = 1'b1;
    set_req(3, 32'd5, 32'd6);
    wait_acks(1, 300);
    check("timeout_err", {res_err, res_sum}, {1'b1, 32'h0});
    never_done = 1'b0;
    lat = 4;
    set_req(3, 32'd7, 32'd8);
    wait_acks(1, 200);
    check("after_timeout", {res_err, res_sum}, {1'b0, 32'd15});

    // Fairness: all requesters continuously re-requesting
    order.delete();
    auto_mode = 1'b1;
    rand_lat  = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, $urandom, $urandom);
    wait_acks(3 * NREQ, 3000);
    check("fair_count", order.size() >= 3 * NREQ, 1);
    for (int k = 0; k < order.size() && k < 3 * NREQ; k++)
      check("fair_order", order[k], k % NREQ);

    // Random re-request gaps
    rand_gap = 1'b1;
    wait_acks(30, 5000);
    auto_mode = 1'b0;
    b = 0;
    while ((req != '0 || inflight || raise_cnt[0] > 0 || raise_cnt[1] > 0 ||
            raise_cnt[2] > 0 || raise_cnt[3] > 0) && b < 2000) begin
      tick();
      b++;
    end
    check("drained", b < 2000, 1);

    // Reset three cycles into WAIT
    rand_lat = 1'b0;
    lat = 20;
    set_req(1, 32'h100, 32'h200);
    b = 0;
    while (!ld_prev && b < 50) begin
      tick();
      b++;
    end
    check("rst_test_load", ld_prev, 1);
    repeat (4) tick();
    acks_before = acks;
    reset_and_check();
    repeat (2) tick();
    check("no_ack_on_abort", acks, acks_before);
    rst = 1'b0;
    wait_acks(1, 200);
    check("regrant_id", order[$], 1);
    check("regrant_sum", {res_err, res_sum}, {1'b0, 32'h300});
    repeat (3) tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
